// File: rtl/ppu_pkg.sv
// Shared PPU definitions: palette sequencer states, palette address width
// and the NES palette mirroring rule.
package ppu_pkg;

   localparam int PAL_ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      DONE = 2'd2
   } pal_state_t;

   // Backdrop entries $10/$14/$18/$1C alias onto $00/$04/$08/$0C.
   function automatic logic [PAL_ADDR_W-1:0] pal_mirror(input logic [PAL_ADDR_W-1:0] addr);
      logic [PAL_ADDR_W-1:0] m;
      m = addr;
      if (addr[4] && (addr[1:0] == 2'b00))
         m[4] = 1'b0;
      return m;
   endfunction

endpackage

// File: rtl/pal_ctrl.sv
// Palette RAM sequencer: shares the single RAM port between renderer lookups
// and CPU PPUDATA accesses, with bounded CPU starvation and greyscale output.
module pal_ctrl
   import ppu_pkg::*;
#(
   parameter int STARVE_MAX = 8,
   parameter int ADDR_W     = PAL_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_en,
   input  logic              greyscale,
   input  logic              rnd_req,
   input  logic [ADDR_W-1:0] rnd_addr,
   output logic [5:0]        rnd_data,
   output logic              rnd_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic              cpu_ack,
   output logic [7:0]        cpu_rdata,
   output logic [ADDR_W-1:0] pal_addr,
   output logic              pal_we,
   output logic [7:0]        pal_wdata,
   input  logic [7:0]        pal_rdata
);

   localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
   localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

   pal_state_t        state, state_nxt;
   logic [SW-1:0]     starve;
   logic              buf_we;
   logic [ADDR_W-1:0] buf_addr;
   logic [7:0]        buf_wdata;
   logic              armed;
   logic              starved;
   logic              cpu_sel;
   logic              cpu_go;
   logic              rnd_go;

   function automatic logic [ADDR_W-1:0] mirror(input logic [ADDR_W-1:0] a);
      return ADDR_W'(pal_mirror(PAL_ADDR_W'(a)));
   endfunction

   function automatic logic [5:0] grey(input logic [7:0] d, input logic g);
      return g ? {d[5:4], 4'b0000} : d[5:0];
   endfunction

   assign starved = (starve == STARVE_LAST);

   always_comb begin
      state_nxt = state;
      cpu_sel   = 1'b0;
      cpu_go    = 1'b0;
      rnd_go    = 1'b0;
      case (state)
         IDLE: begin
            rnd_go = clk_en & rnd_req;
            if (cpu_req && !cpu_ack && armed)
               state_nxt = PEND;
         end
         PEND: begin
            // Renderer keeps the port unless it is idle or the CPU has waited too long.
            cpu_sel = !rnd_req || starved;
            cpu_go  = clk_en & cpu_sel;
            rnd_go  = clk_en & !cpu_sel;
            if (cpu_go)
               state_nxt = DONE;
         end
         DONE: begin
            rnd_go = clk_en & rnd_req;
            if (clk_en)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign pal_addr  = cpu_sel ? mirror(buf_addr) : (rnd_req ? mirror(rnd_addr) : '0);
   assign pal_we    = cpu_go & buf_we;
   assign pal_wdata = (cpu_sel && buf_we) ? buf_wdata : 8'h00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Request capture and ack handshake; capture happens on any clk, not only enabled ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_we    <= 1'b0;
         buf_addr  <= '0;
         buf_wdata <= 8'h00;
         starve    <= '0;
         armed     <= 1'b1;
         cpu_ack   <= 1'b0;
         cpu_rdata <= 8'h00;
      end else begin
         if (state == IDLE && state_nxt == PEND) begin
            buf_we    <= cpu_we;
            buf_addr  <= cpu_addr;
            buf_wdata <= cpu_wdata;
         end
         if (state == DONE)
            starve <= '0;
         else if (state == PEND && rnd_go)
            starve <= starve + 1'b1;
         if (cpu_go)
            armed <= 1'b0;
         else if (!cpu_req)
            armed <= 1'b1;
         cpu_ack <= cpu_go;
         if (cpu_go && !buf_we)
            cpu_rdata <= {2'b00, pal_rdata[5:0]};
      end
   end

   // Render result stage: valid for one enabled period, data held on drop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rnd_valid <= 1'b0;
         rnd_data  <= 6'h00;
      end else if (clk_en) begin
         rnd_valid <= rnd_go;
         if (rnd_go)
            rnd_data <= grey(pal_rdata, greyscale);
      end
   end

endmodule

// File: doc/pal_ctrl.md
Name: pal_ctrl

Overview:
Sequencer and arbiter for the 32-byte palette RAM. It shares the single RAM port between two requesters:
- the renderer's pixel-colour lookups;
- CPU accesses through PPUDATA to $3F00-$3FFF.

It also applies NES palette mirroring and PPUMASK greyscale. It sits between the PPU register block, the pixel pipeline and the palette RAM instance.

Parameters:
- STARVE_MAX, 8, number of consecutive enabled cycles a pending CPU access may be denied before it is forced through.
- ADDR_W, 5, palette RAM address width.

Ports:
- clk  in  1  master clock
- rst_n  in  1  asynchronous active-low reset
- clk_en  in  1  PPU clock enable (master/4); all state advances only when high
- greyscale  in  1  PPUMASK bit 0
- rnd_req  in  1  renderer lookup request (sampled on clk_en)
- rnd_addr  in  ADDR_W  renderer palette index
- rnd_data  out  6  colour returned to renderer
- rnd_valid  out  1  rnd_data updated this enabled cycle
- cpu_req  in  1  CPU access request (level, held until cpu_ack)
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU palette address (low 5 bits of $3Fxx)
- cpu_wdata  in  8  write data
- cpu_ack  out  1  one-clk pulse: access complete
- cpu_rdata  out  8  read result, valid with cpu_ack and held after
- pal_addr  out  ADDR_W  palette RAM address
- pal_we  out  1  palette RAM write enable
- pal_wdata  out  8  palette RAM write data
- pal_rdata  in  8  palette RAM combinational read data

Behaviour:
- Reset values (asynchronous): all outputs 0; state IDLE; starve counter 0; CPU buffer cleared.
- Mirroring, applied to both requesters: if addr[4]=1 and addr[1:0]=00, clear addr[4]. Example: $10 maps to $00, $1C to $0C, $11 is unchanged.
- Greyscale: if greyscale=1, rnd_data = pal_rdata[5:4],4'b0000; otherwise rnd_data = pal_rdata[5:0]. CPU reads are never greyscaled.
- cpu_rdata = 2'b00, pal_rdata[5:0].
- State machine, advancing only on clk_en:
  - IDLE: if cpu_req=1 and cpu_ack=0, latch we/addr/wdata into a 1-entry buffer and go to PEND. Latching does not need clk_en, so the request is captured on the first clk edge.
  - PEND, per enabled cycle:
    - rnd_req=0: do the CPU access and go to DONE.
    - rnd_req=1 and starve<STARVE_MAX-1: serve the renderer and increment starve.
    - rnd_req=1 and starve=STARVE_MAX-1: force the CPU access, drop the render lookup (rnd_valid=0), go to DONE.
  - DONE: pulse cpu_ack for exactly one clk, capture cpu_rdata on reads, clear starve, return to IDLE. Further cpu_req is ignored until cpu_req has been seen low for at least one clk after the ack.
- Port driving: pal_addr/pal_we/pal_wdata are combinational from the winning requester in the current enabled cycle. pal_we is asserted only in the CPU-access cycle and only when clk_en=1.
- Render path:
  - Latency 0 to RAM. rnd_data/rnd_valid are registered at the clk_en edge of the accepted request.
  - rnd_valid is high for the following clk_en period only.
  - A dropped lookup leaves rnd_data holding its previous value.
- Simultaneous events:
  - Renderer wins every cycle except a forced cycle.
  - A CPU write and a render read to the same mirrored address in one cycle cannot occur (single port).
  - A render read in the enabled cycle after a write sees the new data.
- clk_en=0: no state change, pal_we=0, outputs hold.
- Reset mid-operation: any pending CPU access is discarded with no ack. No partial write occurs because pal_we is combinational and reset forces IDLE.

Decomposition:
- Shared package ppu_pkg holds:
  - typedef enum pal_state_t {IDLE, PEND, DONE};
  - localparam PAL_ADDR_W=5;
  - function pal_mirror(addr) returning the mirrored address, also used by the PPU register block.
- No sub-module: the mirror function is inlined. The starve counter is a width $clog2(STARVE_MAX) register inside pal_ctrl.

Test Plan:
- CPU write $11 data $2A, rnd_req=0 -> pal_we on the next enabled cycle with pal_addr=$11, cpu_ack one clk later; subsequent render read of $11 returns $2A.
- CPU write $10 data $0F, then render read $00 -> rnd_data=$0F; CPU read $14 after writing $04 with $16 -> cpu_rdata=$16.
- rnd_req held high continuously, CPU write pending -> renderer served 7 enabled cycles, 8th cycle forced write with rnd_valid=0, cpu_ack follows.
- greyscale=1, entry $00=$27, render read $00 -> rnd_data=$20; CPU read of $00 -> cpu_rdata=$27.
- clk_en pulsed every 4th clk, CPU read with no render traffic -> cpu_ack exactly one clk wide, cpu_rdata stable until the next access.
- rst_n asserted while in PEND -> no pal_we, no cpu_ack, all outputs 0, state IDLE after deassert.
